div_clk_monitor: RTL and testbench

Checker stage that sits directly downstream of the even divide-by-N clock divider and consumes its divided output `div_clk` as a data signal in the `clk` domain. It detects rising and falling edges, measures the length of each half-period in `clk` cycles, and compares that length against a programmable expected value. It declares lock after a run of consecutive good half-periods and flags mismatches and a stuck (non-toggling) divider. Its outputs drive the status/debug path and gate logic that must not use the divided clock until it is stable.

---
 rtl/div_clk_monitor.sv | 197 +++++++++++++++++++
 tb/tb_div_clk_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Monitors a divided clock sampled as data in the clk domain: measures each
// half-period, locks after a run of matching halves, flags mismatches and stalls.
module div_clk_monitor #(
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_clk,
   input  logic [CNT_W-1:0] exp_half,
   input  logic             err_clr,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] half_last,
   output logic [15:0]      edge_cnt,
   output logic             lock,
   output logic             err,
   output logic             stuck
);

   localparam int                 MATCH_W   = $clog2(LOCK_CNT + 1);
   localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);
   localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
   localparam logic [CNT_W-1:0]   R_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   R_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_ACQ   = 2'd0,
      ST_TRACK = 2'd1,
      ST_LOCK  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               prev_q, prev_d;
   logic [CNT_W-1:0]   r_q, r_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic [CNT_W-1:0]   half_last_q, half_last_d;
   logic [15:0]        edge_cnt_q, edge_cnt_d;
   logic               lock_q, lock_d;
   logic               err_q, err_d;
   logic               stuck_q, stuck_d;

   logic               edge_s;
   logic               sat_s;
   logic               hit_s;
   logic [MATCH_W-1:0] match_inc_s;
   logic               err_set_s;
   logic               stuck_set_s;

   // Edge detection, run counter, acquisition FSM and sticky flag updates.
   always_comb begin
      edge_s      = (div_clk != prev_q);
      sat_s       = (r_q == R_MAX);
      // A zero expectation can never match, so the block never locks on it.
      hit_s       = (r_q == exp_half) && (exp_half != {CNT_W{1'b0}});
      match_inc_s = (match_q == MATCH_MAX) ? match_q : (match_q + MATCH_ONE);

      prev_d      = div_clk;
      state_d     = state_q;
      match_d     = match_q;
      half_last_d = half_last_q;
      err_set_s   = 1'b0;
      stuck_set_s = 1'b0;
      rise_d      = edge_s & div_clk;
      fall_d      = edge_s & ~div_clk;

      if (edge_s) begin
         r_d        = R_ONE;
         edge_cnt_d = edge_cnt_q + 16'd1;
      end else if (sat_s) begin
         r_d        = r_q;
         edge_cnt_d = edge_cnt_q;
      end else begin
         r_d        = r_q + R_ONE;
         edge_cnt_d = edge_cnt_q;
      end

      case (state_q)
         ST_ACQ: begin
            match_d = {MATCH_W{1'b0}};
            if (edge_s) begin
               state_d = ST_TRACK;
            end else begin
               state_d = ST_ACQ;
            end
         end
         ST_TRACK: begin
            if (edge_s) begin
               half_last_d = r_q;
               if (hit_s) begin
                  match_d = match_inc_s;
                  if (match_inc_s == MATCH_MAX) begin
                     state_d = ST_LOCK;
                  end else begin
                     state_d = ST_TRACK;
                  end
               end else begin
                  match_d = {MATCH_W{1'b0}};
                  state_d = ST_TRACK;
               end
            end else begin
               state_d = ST_TRACK;
            end
         end
         ST_LOCK: begin
            if (edge_s) begin
               half_last_d = r_q;
               if (hit_s) begin
                  state_d = ST_LOCK;
               end else begin
                  err_set_s = 1'b1;
                  match_d   = {MATCH_W{1'b0}};
                  state_d   = ST_TRACK;
               end
            end else begin
               state_d = ST_LOCK;
            end
         end
         default: begin
            state_d = ST_ACQ;
            match_d = {MATCH_W{1'b0}};
         end
      endcase

      // A saturated run with no edge means the divider stopped toggling.
      if (sat_s && !edge_s) begin
         stuck_set_s = 1'b1;
         state_d     = ST_ACQ;
         match_d     = {MATCH_W{1'b0}};
         if (state_q == ST_LOCK) begin
            err_set_s = 1'b1;
         end else begin
            err_set_s = 1'b0;
         end
      end else begin
         stuck_set_s = 1'b0;
      end

      if (err_set_s) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      if (stuck_set_s) begin
         stuck_d = 1'b1;
      end else if (err_clr) begin
         stuck_d = 1'b0;
      end else begin
         stuck_d = stuck_q;
      end

      lock_d = (state_d == ST_LOCK);
   end

   // State and output registers; synchronous reset re-arms edge detection on the current level.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q      <= div_clk;
         r_q         <= {CNT_W{1'b0}};
         state_q     <= ST_ACQ;
         match_q     <= {MATCH_W{1'b0}};
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         half_last_q <= {CNT_W{1'b0}};
         edge_cnt_q  <= 16'd0;
         lock_q      <= 1'b0;
         err_q       <= 1'b0;
         stuck_q     <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         r_q         <= r_d;
         state_q     <= state_d;
         match_q     <= match_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         half_last_q <= half_last_d;
         edge_cnt_q  <= edge_cnt_d;
         lock_q      <= lock_d;
         err_q       <= err_d;
         stuck_q     <= stuck_d;
      end
   end

   assign rise      = rise_q;
   assign fall      = fall_q;
   assign half_last = half_last_q;
   assign edge_cnt  = edge_cnt_q;
   assign lock      = lock_q;
   assign err       = err_q;
   assign stuck     = stuck_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: directed scenarios plus random level lengths
// checked against a time-based reference model.
module tb_div_clk_monitor;

   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 4;
   localparam int RMAX     = 255;
   localparam int MD_ACQ   = 0;
   localparam int MD_TRACK = 1;
   localparam int MD_LOCK  = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             div_clk = 1'b1;
   logic [CNT_W-1:0] exp_half = 8'd3;
   logic             err_clr = 1'b0;
   logic             rise, fall, lock, err, stuck;
   logic [CNT_W-1:0] half_last;
   logic [15:0]      edge_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: run length from the cycle of the last edge / reset
   int          m_cyc = 0;
   int          m_base = 0;
   int          m_mode = MD_ACQ;
   int          m_good = 0;
   logic        m_prev = 1'b0;
   logic        m_rise = 1'b0, m_fall = 1'b0, m_lock = 1'b0, m_err = 1'b0, m_stuck = 1'b0;
   logic [7:0]  m_half = 8'd0;
   logic [15:0] m_edges = 16'd0;

   always #5 clk = ~clk;

   div_clk_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
      .clk(clk), .reset(reset), .div_clk(div_clk), .exp_half(exp_half),
      .err_clr(err_clr), .rise(rise), .fall(fall), .half_last(half_last),
      .edge_cnt(edge_cnt), .lock(lock), .err(err), .stuck(stuck)
   );

   task automatic model_step();
      int   r;
      logic e, err_set, stuck_set;
      if (reset) begin
         m_prev = div_clk; m_base = m_cyc + 1; m_mode = MD_ACQ; m_good = 0;
         m_rise = 0; m_fall = 0; m_lock = 0; m_err = 0; m_stuck = 0;
         m_half = 8'd0; m_edges = 16'd0;
      end else begin
         r = m_cyc - m_base;
         if (r > RMAX) r = RMAX;
         e = (div_clk !== m_prev);
         m_rise = e && div_clk;
         m_fall = e && !div_clk;
         err_set = 0; stuck_set = 0;
         if (e) begin
            m_edges = m_edges + 16'd1;
            m_base = m_cyc;
            if (m_mode == MD_ACQ) begin
               m_mode = MD_TRACK; m_good = 0;
            end else begin
               m_half = r[7:0];
               if (r == int'(exp_half) && exp_half != 8'd0) begin
                  if (m_mode == MD_TRACK) begin
                     m_good++;
                     if (m_good >= LOCK_CNT) m_mode = MD_LOCK;
                  end
               end else begin
                  if (m_mode == MD_LOCK) err_set = 1;
                  m_good = 0; m_mode = MD_TRACK;
               end
            end
         end else if (r == RMAX) begin
            stuck_set = 1;
            if (m_mode == MD_LOCK) err_set = 1;
            m_mode = MD_ACQ; m_good = 0;
         end
         if (err_set) m_err = 1; else if (err_clr) m_err = 0;
         if (stuck_set) m_stuck = 1; else if (err_clr) m_stuck = 0;
         m_lock = (m_mode == MD_LOCK);
         m_prev = div_clk;
      end
      m_cyc++;
   endtask

   task automatic tick(input logic lvl, input logic clr, input logic rst);
      div_clk = lvl; err_clr = clr; reset = rst;
      @(posedge clk);
      model_step();
      #1;
      err_clr = 1'b0; reset = 1'b0;
   endtask

   task automatic hold(input logic lvl, input int n);
      for (int i = 0; i < n; i++) tick(lvl, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      exp_half = 8'd3;
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      n_cmp++;
      if ({rise, fall, lock, err, stuck, half_last, edge_cnt} !== 29'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", {rise, fall, lock, err, stuck, half_last, edge_cnt});
      end
      tick(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (rise !== 1'b0 || fall !== 1'b0 || edge_cnt !== 16'd0) begin
         n_bad++; $display("FAIL release_no_edge: got rise=%b fall=%b edges=%0d want 0 0 0", rise, fall, edge_cnt);
      end
   endtask

   task automatic test_lock_n6();
      hold(1'b1, 2); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3);
      n_cmp++;
      if (lock !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b want 0", lock); end
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (lock !== 1'b1 || half_last !== 8'd3 || edge_cnt !== 16'd5) begin
         n_bad++; $display("FAIL lock_e5: got lock=%b half=%0d edges=%0d want 1 3 5", lock, half_last, edge_cnt);
      end
      hold(1'b0, 2);
   endtask

   task automatic test_stretch();
      hold(1'b1, 4);
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (err !== 1'b1 || lock !== 1'b0 || half_last !== 8'd4) begin
         n_bad++; $display("FAIL stretch_err: got err=%b lock=%b half=%0d want 1 0 4", err, lock, half_last);
      end
      hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3);
      n_cmp++;
      if (lock !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %b want 0", lock); end
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (lock !== 1'b1 || err !== 1'b1 || half_last !== 8'd3) begin
         n_bad++; $display("FAIL relock: got lock=%b err=%b half=%0d want 1 1 3", lock, err, half_last);
      end
      hold(1'b0, 2); hold(1'b1, 1);
      tick(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (err !== 1'b0 || lock !== 1'b1) begin
         n_bad++; $display("FAIL err_clr: got err=%b lock=%b want 0 1", err, lock);
      end
      hold(1'b1, 1);
   endtask

   task automatic test_clr_collision();
      hold(1'b0, 2);
      tick(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (err !== 1'b1 || half_last !== 8'd2 || lock !== 1'b0) begin
         n_bad++; $display("FAIL clr_collision: got err=%b half=%0d lock=%b want 1 2 0", err, half_last, lock);
      end
      hold(1'b1, 2); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
      tick(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (lock !== 1'b1) begin n_bad++; $display("FAIL relock2: got %b want 1", lock); end
      hold(1'b1, 1);
      tick(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr2: got %b want 0", err); end
   endtask

   task automatic test_stuck();
      hold(1'b0, 1);
      for (int i = 0; i < 300; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (stuck !== m_stuck) begin
            n_bad++; $display("FAIL stuck_timing: cycle %0d got %b want %b", i, stuck, m_stuck);
         end
      end
      n_cmp++;
      if (stuck !== 1'b1 || err !== 1'b1 || lock !== 1'b0) begin
         n_bad++; $display("FAIL stuck_flags: got stuck=%b err=%b lock=%b want 1 1 0", stuck, err, lock);
      end
      tick(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (half_last !== 8'd3 || rise !== 1'b1 || edge_cnt !== m_edges) begin
         n_bad++; $display("FAIL stuck_acq_edge: got half=%0d rise=%b edges=%0d want 3 1 %0d", half_last, rise, edge_cnt, m_edges);
      end
      hold(1'b1, 4);
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (half_last !== 8'd5) begin n_bad++; $display("FAIL track_after_acq: got %0d want 5", half_last); end
      tick(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (err !== 1'b0 || stuck !== 1'b0) begin
         n_bad++; $display("FAIL stuck_clr: got err=%b stuck=%b want 0 0", err, stuck);
      end
   endtask

   task automatic test_exp1();
      logic lvl;
      exp_half = 8'd1;
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         lvl = (i % 2 == 0) ? 1'b1 : 1'b0;
         tick(lvl, 1'b0, 1'b0);
         n_cmp++;
         if (rise !== lvl || fall !== ~lvl) begin
            n_bad++; $display("FAIL exp1_edges: step %0d got rise=%b fall=%b want %b %b", i, rise, fall, lvl, ~lvl);
         end
         n_cmp++;
         if (lock !== (i >= 4)) begin
            n_bad++; $display("FAIL exp1_lock: step %0d got %b want %b", i, lock, (i >= 4));
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_half = 8'd3;
      tick(1'b0, 1'b0, 1'b1);
      hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
      tick(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (lock !== 1'b1) begin n_bad++; $display("FAIL mid_prelock: got %b want 1", lock); end
      hold(1'b1, 1);
      tick(1'b1, 1'b0, 1'b1);
      n_cmp++;
      if ({rise, fall, lock, err, stuck, half_last, edge_cnt} !== 29'd0) begin
         n_bad++; $display("FAIL mid_reset: got %h want 0", {rise, fall, lock, err, stuck, half_last, edge_cnt});
      end
      hold(1'b1, 1);
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (half_last !== 8'd0 || lock !== 1'b0 || edge_cnt !== 16'd1) begin
         n_bad++; $display("FAIL mid_first_edge: got half=%0d lock=%b edges=%0d want 0 0 1", half_last, lock, edge_cnt);
      end
      hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3);
      n_cmp++;
      if (lock !== 1'b0) begin n_bad++; $display("FAIL mid_lock_e4: got %b want 0", lock); end
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (lock !== 1'b1) begin n_bad++; $display("FAIL mid_lock_e5: got %b want 1", lock); end
      hold(1'b0, 2);
   endtask

   task automatic test_random();
      int   len, sel;
      logic lvl;
      for (int seg = 0; seg < 250; seg++) begin
         if (seg % 25 == 0) exp_half = 8'($urandom_range(1, 6));
         sel = $urandom_range(0, 99);
         if (sel < 70) len = int'(exp_half);
         else if (sel < 97) len = $urandom_range(1, 8);
         else len = $urandom_range(250, 270);
         lvl = ~div_clk;
         for (int c = 0; c < len; c++) begin
            tick(lvl, ($urandom_range(0, 31) == 0), ($urandom_range(0, 299) == 0));
            n_cmp++;
            if (rise !== m_rise || fall !== m_fall) begin
               n_bad++; $display("FAIL rnd_edge: cyc %0d got %b%b want %b%b", m_cyc, rise, fall, m_rise, m_fall);
            end
            n_cmp++;
            if (half_last !== m_half) begin
               n_bad++; $display("FAIL rnd_half: cyc %0d got %0d want %0d", m_cyc, half_last, m_half);
            end
            n_cmp++;
            if (edge_cnt !== m_edges) begin
               n_bad++; $display("FAIL rnd_edges: cyc %0d got %0d want %0d", m_cyc, edge_cnt, m_edges);
            end
            n_cmp++;
            if (lock !== m_lock || err !== m_err || stuck !== m_stuck) begin
               n_bad++; $display("FAIL rnd_flags: cyc %0d got l/e/s=%b%b%b want %b%b%b", m_cyc, lock, err, stuck, m_lock, m_err, m_stuck);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock_n6();
      test_stretch();
      test_clr_collision();
      test_stuck();
      test_exp1();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
